// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the prefix adder/subtractor family:
// generate/propagate pair type, prefix combine operator and default sizing.
package arith_pkg;

    localparam int WIDTH_DEFAULT = 6;
    localparam int PREFIX_LEVELS = $clog2(WIDTH_DEFAULT);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_net.sv
// Combinational Kogge-Stone carry network: carries c[0..WIDTH] from per-bit
// generate/propagate and a carry-in. Shared with the prefix adder.
module prefix_net
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic             cin_i,
    output logic [WIDTH:0]   c_o
);

    localparam int LEVELS = $clog2(WIDTH);

    gp_t lvl [LEVELS+1][WIDTH];

    // Level l combines each bit with the span ending 2^l positions below it.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            lvl[0][i].g = g_i[i];
            lvl[0][i].p = p_i[i];
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    lvl[l+1][i] = gp_combine(lvl[l][i], lvl[l][i-(1<<l)]);
                end else begin
                    lvl[l+1][i] = lvl[l][i];
                end
            end
        end
        c_o[0] = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            c_o[i+1] = lvl[LEVELS][i].g | (lvl[LEVELS][i].p & cin_i);
        end
    end

endmodule

// File: rtl/sub_pipe6.sv
// Two-stage pipelined prefix subtractor D = X - Y (as X + ~Y + 1) with
// valid/ready handshakes on both sides, unsigned borrow and signed overflow.
module sub_pipe6
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             ovf
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] g_q, g_d, p_q, p_d, h_q, h_d;
    logic             xs_q, xs_d, ys_q, ys_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d, ovf_q, ovf_d;
    logic [WIDTH:0]   c;
    logic             s1_adv, s2_adv, in_xfer;

    assign s2_adv  = ~s2_valid_q | out_ready;
    assign s1_adv  = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid & s1_adv;

    prefix_net #(.WIDTH(WIDTH)) u_prefix (
        .g_i   (g_q),
        .p_i   (p_q),
        .cin_i (1'b1),
        .c_o   (c)
    );

    // Stage 1 captures g/p/h of X + ~Y; stage 2 resolves carries into D.
    always_comb begin
        s1_valid_d = s1_valid_q;
        g_d        = g_q;
        p_d        = p_q;
        h_d        = h_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        if (s1_adv) begin
            s1_valid_d = in_xfer;
            if (in_xfer) begin
                g_d  = X & ~Y;
                p_d  = X | ~Y;
                h_d  = X ^ ~Y;
                xs_d = X[WIDTH-1];
                ys_d = Y[WIDTH-1];
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d    = h_q ^ c[WIDTH-1:0];
                bout_d = ~c[WIDTH];
                ovf_d  = (xs_q != ys_q) && (d_d[WIDTH-1] != xs_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            g_q        <= '0;
            p_q        <= '0;
            h_q        <= '0;
            xs_q       <= 1'b0;
            ys_q       <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            g_q        <= g_d;
            p_q        <= p_d;
            h_q        <= h_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign D         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_pipe6.sv
// Self-checking bench for sub_pipe6: boundary vector table, backpressure and
// mid-operation reset sequences, and random streams against an arithmetic model.
module tb_sub_pipe6;

    localparam int W = 6;

    typedef struct {
        int x;
        int y;
        int d;
        int b;
        int o;
    } vec_t;

    typedef struct {
        int d;
        int b;
        int o;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] D;
    logic         bout;
    logic         ovf;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl [9];

    sub_pipe6 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Plain integer arithmetic: wrap the difference, compare magnitudes,
    // and test the signed difference against the representable range.
    function automatic void refModel(input int x, input int y,
                                     output int d, output int b, output int o);
        int half, sx, sy, sd;
        half = 1 << (W - 1);
        d  = (x - y) & ((1 << W) - 1);
        b  = (x < y) ? 1 : 0;
        sx = (x >= half) ? x - 2 * half : x;
        sy = (y >= half) ? y - 2 * half : y;
        sd = sx - sy;
        o  = (sd >= half || sd < -half) ? 1 : 0;
    endfunction

    // Entered and left just after a rising edge; one isolated transfer.
    task automatic applyStimulus(input vec_t v, input int idx);
        X         = W'(v.x);
        Y         = W'(v.y);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput($sformatf("vec%0d.in_ready", idx), int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput($sformatf("vec%0d.in_ready_s1", idx), int'(in_ready), 1);
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d.out_valid", idx), int'(out_valid), 1);
        checkOutput($sformatf("vec%0d.D", idx), int'(D), v.d);
        checkOutput($sformatf("vec%0d.bout", idx), int'(bout), v.b);
        checkOutput($sformatf("vec%0d.ovf", idx), int'(ovf), v.o);
    endtask

    task automatic runStream(input int n, input bit stall, input string tag);
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit pending = 0;
        while (got < n && cyc < n * 20 + 50) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!pending && sent < n && (!stall || $urandom_range(0, 3) != 0)) begin
                X = W'($urandom_range(0, (1 << W) - 1));
                Y = W'($urandom_range(0, (1 << W) - 1));
                pending = 1;
            end
            in_valid = pending;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checkOutput({tag, ".spurious"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput({tag, ".D"}, int'(D), e.d);
                    checkOutput({tag, ".bout"}, int'(bout), e.b);
                    checkOutput({tag, ".ovf"}, int'(ovf), e.o);
                    if (!stall) checkOutput({tag, ".latency"}, cyc - e.cyc, 2);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                refModel(int'(X), int'(Y), e.d, e.b, e.o);
                e.cyc = cyc;
                q.push_back(e);
                sent++;
                pending = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput({tag, ".results"}, got, n);
    endtask

    task automatic backpressureSeq();
        int srcX [4] = '{10, 20, 0, 7};
        int srcY [4] = '{3, 4, 1, 7};
        int expD [4] = '{7, 16, 63, 0};
        int expB [4] = '{0, 0, 1, 0};
        int nextIn = 0;
        int gotIdx = 0;
        int accepted = 0;
        for (int cyc = 0; cyc < 20 && gotIdx < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (nextIn < 4);
            if (nextIn < 4) begin
                X = W'(srcX[nextIn]);
                Y = W'(srcY[nextIn]);
            end
            #1;
            if (cyc == 2) checkOutput("bp.in_ready_third", int'(in_ready), 0);
            if (cyc == 3) begin
                checkOutput("bp.hold_valid", int'(out_valid), 1);
                checkOutput("bp.hold_D", int'(D), 7);
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp.D%0d", gotIdx), int'(D), expD[gotIdx]);
                checkOutput($sformatf("bp.bout%0d", gotIdx), int'(bout), expB[gotIdx]);
                gotIdx++;
            end
            if (in_valid && in_ready) begin
                if (cyc < 4) accepted++;
                nextIn++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("bp.accepted_stalled", accepted, 2);
        checkOutput("bp.drained", gotIdx, 4);
    endtask

    task automatic midResetSeq();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        X = W'(5);
        Y = W'(13);
        @(posedge clk);
        #1;
        X = W'(31);
        Y = W'(32);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("rst.pre_valid", int'(out_valid), 1);
        checkOutput("rst.pre_D", int'(D), 56);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.out_valid", int'(out_valid), 0);
        checkOutput("rst.D", int'(D), 0);
        checkOutput("rst.bout", int'(bout), 0);
        checkOutput("rst.ovf", int'(ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst.no_stale%0d", i), int'(out_valid), 0);
        end
    endtask

    initial begin
        tbl[0] = '{x: 13, y: 5,  d: 8,  b: 0, o: 0};
        tbl[1] = '{x: 5,  y: 13, d: 56, b: 1, o: 0};
        tbl[2] = '{x: 31, y: 32, d: 63, b: 1, o: 1};
        tbl[3] = '{x: 32, y: 1,  d: 31, b: 0, o: 1};
        tbl[4] = '{x: 0,  y: 1,  d: 63, b: 1, o: 0};
        tbl[5] = '{x: 9,  y: 9,  d: 0,  b: 0, o: 0};
        tbl[6] = '{x: 42, y: 0,  d: 42, b: 0, o: 0};
        tbl[7] = '{x: 0,  y: 63, d: 1,  b: 1, o: 0};
        tbl[8] = '{x: 63, y: 63, d: 0,  b: 0, o: 0};

        #12;
        checkOutput("reset.out_valid", int'(out_valid), 0);
        checkOutput("reset.D", int'(D), 0);
        checkOutput("reset.bout", int'(bout), 0);
        checkOutput("reset.ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset.in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) applyStimulus(tbl[i], i);
        @(posedge clk);
        #1;

        backpressureSeq();
        runStream(64, 1'b0, "full");
        runStream(64, 1'b1, "stall");
        @(posedge clk);
        #1;

        midResetSeq();
        applyStimulus(tbl[8], 8);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule

// File: doc/sub_pipe6.md
Name: sub_pipe6

Overview:
- Two-stage pipelined parallel-prefix subtractor: D = X - Y, computed as X + ~Y + 1.
- Sibling of the team's 6-bit prefix adder, run in the opposite arithmetic direction.
- Adds valid/ready handshakes on input and output, so it can sit between a register-file read port and a result latch under backpressure.
- Flags: unsigned borrow and signed overflow.

Parameters:
- WIDTH, 6: operand/result width in bits; supported range 2..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  X/Y present and valid this cycle.
- in_ready  output  1  block accepts X/Y this cycle.
- X  input  WIDTH  minuend.
- Y  input  WIDTH  subtrahend.
- out_valid  output  1  D/bout/ovf valid.
- out_ready  input  1  consumer accepts the result this cycle.
- D  output  WIDTH  difference X - Y, mod 2^WIDTH.
- bout  output  1  borrow out: 1 iff X < Y as unsigned.
- ovf  output  1  signed overflow: X[W-1] != Y[W-1] and D[W-1] != X[W-1].

Behaviour:
- Reset: while rst_n = 0, s1_valid = s2_valid = 0, out_valid = 0, D = 0, bout = 0, ovf = 0. in_ready = 1 one edge after release. Asserting reset mid-operation discards all in-flight results; no partial output appears.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Stage 1 (on input transfer):
  - Register per-bit g[i] = X[i] & ~Y[i], p[i] = X[i] | ~Y[i], h[i] = X[i] ^ ~Y[i].
  - Register sign bits X[W-1] and Y[W-1] for ovf.
  - Set s1_valid.
- Stage 2:
  - Kogge-Stone prefix over (g, p) with carry-in = 1: c[0] = 1, c[i+1] = G[i:0] | (P[i:0] & 1).
  - D[i] = h[i] ^ c[i]; bout = ~c[W]; compute ovf.
  - Register D, bout, ovf and set s2_valid when stage 1 advances.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1 result/cycle.
- Stall logic:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Holding: outputs hold while out_valid & ~out_ready. Stage 1 holds when stage 2 is held and full.
- Bubbles: stage 2 not loaded from a valid stage 1 clears s2_valid only when out_ready. A stage without a new load clears its valid bit on advance.
- Simultaneous output transfer and new stage-1 data: stage 2 reloads in the same edge; no bubble.
- Arithmetic boundaries:
  - X = Y gives D = 0, bout = 0.
  - Y = 0 gives D = X, bout = 0.
  - X = 0, Y = 1 gives D = all-ones, bout = 1.
- Order: strictly FIFO; no reordering or dropping.
- in_valid = 0 leaves registered operand contents don't-care. X/Y are sampled only on an input transfer.

Decomposition:
- Shared package arith_pkg:
  - WIDTH default.
  - gp_t struct {g, p}.
  - Prefix-combine function: (Gh | Ph & Gl, Ph & Pl).
  - Log2 depth constant for the prefix levels.
- One natural sub-module: prefix_net (combinational Kogge-Stone carry network, WIDTH-generic, inputs g/p/cin, output c[WIDTH:0]). It is reusable by the existing adder in any re-synthesis.
- Handshake and stage registers live in sub_pipe6.

Test Plan:
- Reset then X = 13, Y = 5, in_valid one cycle, out_ready = 1 -> two cycles later out_valid = 1, D = 8, bout = 0, ovf = 0; in_ready high throughout.
- X = 5, Y = 13 -> D = 56 (6'b111000), bout = 1, ovf = 0.
- X = 31, Y = 32 (signed +31 - (-32)) -> D = 63, bout = 1, ovf = 1. Also X = 32, Y = 1 -> D = 31, bout = 0, ovf = 1.
- Backpressure: out_ready = 0 for 4 cycles while 4 back-to-back inputs are offered (A-B = 10-3, 20-4, 0-1, 7-7) -> exactly 2 accepted; in_ready = 0 from the third offer. D holds 7 until out_ready = 1. Then results drain in order 7, 16, 63 (bout 1), 0, with no loss or duplication.
- Full throughput: 64 consecutive random pairs with out_ready = 1 -> 64 results, each 2 cycles after its input, matching a reference model for D/bout/ovf.
- Reset mid-operation: rst_n low one cycle with both stages valid -> out_valid, D, bout, ovf go to 0 immediately (asynchronously). No stale result appears after release; the next accepted pair (63 - 63) yields D = 0, bout = 0.
